// File: rtl/can_mailbox_ctrl_if.sv
// can_mailbox_ctrl_if: Wishbone slave bus bundle for the CAN mailbox controller
interface can_mailbox_ctrl_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  modport slave (input wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, output wb_dat_o, wb_ack_o);
  modport master (output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, input wb_dat_o, wb_ack_o);
endinterface

// File: rtl/can_mailbox_ctrl.sv
// can_mailbox_ctrl: Wishbone CAN controller model with TX mailbox, acceptance filter, RX FIFO and irq
module can_mailbox_ctrl #(
  parameter int RX_DEPTH  = 4,
  parameter int TX_DELAY  = 16,
  parameter bit LOOPBACK0 = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  can_mailbox_ctrl_if.slave   wb,
  output logic                rx_ready,
  output logic [10:0]         rx_id,
  output logic [3:0]          rx_dlc,
  output logic [63:0]         rx_data,
  output logic                tx_done,
  output logic                irq
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = $clog2(RX_DEPTH + 1);
  localparam int DW = $clog2(TX_DELAY + 1);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_d;
  logic ack_q, tx_done_q, ovf_q;
  logic [31:0] dat_q, rdata;
  logic [10:0] tx_id_q, acc_code_q, acc_mask_q, s_id_q;
  logic [3:0] tx_dlc_q, s_dlc_q, dlc_c;
  logic [63:0] tx_data_q, s_data_q, payload;
  logic [1:0] ctrl_q;
  logic [DW-1:0] cnt_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic [10:0] f_id_q [RX_DEPTH];
  logic [3:0] f_dlc_q [RX_DEPTH];
  logic [63:0] f_data_q [RX_DEPTH];
  logic accept, wr, cmd, send, pop, clr, deliver, full, pass, push, ovf_set;
  logic [3:0] rsel;
  logic unused_adr;
  assign unused_adr = ^{wb.wb_adr_i[31:6], wb.wb_adr_i[1:0]};
  assign rsel     = wb.wb_adr_i[5:2];
  assign accept   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr       = accept & wb.wb_we_i;
  assign cmd      = wr && rsel == 4'h0;
  assign send     = cmd & wb.wb_dat_i[0];
  assign pop      = cmd & wb.wb_dat_i[1] & rx_ready;
  assign clr      = cmd & wb.wb_dat_i[2];
  assign deliver  = state_q == BUSY && cnt_q == '0;
  assign full     = count_q == CW'(RX_DEPTH);
  assign pass     = ctrl_q[0] && ((s_id_q ^ acc_code_q) & acc_mask_q) == 11'h0;
  // a pop on the delivery edge frees the slot the new frame needs
  assign push     = deliver & pass & (~full | pop);
  assign ovf_set  = deliver & pass & full & ~pop;
  assign rx_ready = count_q != '0;
  assign rx_id    = rx_ready ? f_id_q[rd_q] : 11'h0;
  assign rx_dlc   = rx_ready ? f_dlc_q[rd_q] : 4'h0;
  assign rx_data  = rx_ready ? f_data_q[rd_q] : 64'h0;
  assign tx_done  = tx_done_q;
  assign irq      = ctrl_q[1] & (rx_ready | ovf_q);
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  always_comb begin
    state_d = state_q == IDLE ? (send ? BUSY : IDLE) : (deliver ? IDLE : BUSY);
    dlc_c = tx_dlc_q > 4'd8 ? 4'd8 : tx_dlc_q;
    payload = '0;
    for (int i = 0; i < 8; i++) payload[8*i +: 8] = 4'(i) < dlc_c ? tx_data_q[8*i +: 8] : 8'h0;
  end
  always_comb begin
    rdata = '0;
    case (rsel)
      4'h1: rdata = {16'h0, 8'(count_q), 4'h0, full, ovf_q, state_q == BUSY, rx_ready};
      4'h2: rdata = {21'h0, tx_id_q};
      4'h3: rdata = {28'h0, tx_dlc_q};
      4'h4: rdata = tx_data_q[31:0];
      4'h5: rdata = tx_data_q[63:32];
      4'h6: rdata = {21'h0, rx_id};
      4'h7: rdata = {28'h0, rx_dlc};
      4'h8: rdata = rx_data[31:0];
      4'h9: rdata = rx_data[63:32];
      4'hA: rdata = {21'h0, acc_code_q};
      4'hB: rdata = {21'h0, acc_mask_q};
      4'hC: rdata = {30'h0, ctrl_q};
      default: rdata = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      tx_done_q  <= 1'b0;
      ovf_q      <= 1'b0;
      tx_id_q    <= '0;
      tx_dlc_q   <= '0;
      tx_data_q  <= '0;
      acc_code_q <= '0;
      acc_mask_q <= '0;
      ctrl_q     <= {1'b0, LOOPBACK0};
      s_id_q     <= '0;
      s_dlc_q    <= '0;
      s_data_q   <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= accept;
      dat_q     <= accept & ~wb.wb_we_i ? rdata : 32'h0;
      tx_done_q <= deliver;
      ovf_q     <= ovf_set | (ovf_q & ~clr);
      if (wr) begin
        case (rsel)
          4'h2: tx_id_q <= wb.wb_dat_i[10:0];
          4'h3: tx_dlc_q <= wb.wb_dat_i[3:0];
          4'h4: tx_data_q[31:0] <= wb.wb_dat_i;
          4'h5: tx_data_q[63:32] <= wb.wb_dat_i;
          4'hA: acc_code_q <= wb.wb_dat_i[10:0];
          4'hB: acc_mask_q <= wb.wb_dat_i[10:0];
          4'hC: ctrl_q <= wb.wb_dat_i[1:0];
          default: ;
        endcase
      end
      if (state_q == IDLE && send) begin
        s_id_q   <= tx_id_q;
        s_dlc_q  <= dlc_c;
        s_data_q <= payload;
        cnt_q    <= DW'(TX_DELAY - 1);
      end else if (state_q == BUSY && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      f_id_q[wr_q]   <= s_id_q;
      f_dlc_q[wr_q]  <= s_dlc_q;
      f_data_q[wr_q] <= s_data_q;
    end
  end
endmodule

// File: tb/tb_can_mailbox_ctrl.sv
// tb_can_mailbox_ctrl: directed and randomized checks of can_mailbox_ctrl against a frame-level model
module tb_can_mailbox_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  can_mailbox_ctrl_if bus ();
  logic rx_ready, tx_done, irq;
  logic [10:0] rx_id;
  logic [3:0] rx_dlc;
  logic [63:0] rx_data;
  can_mailbox_ctrl #(.RX_DEPTH(4), .TX_DELAY(16), .LOOPBACK0(1'b1)) dut (
    .clk(clk), .rst(rst), .wb(bus), .rx_ready(rx_ready), .rx_id(rx_id), .rx_dlc(rx_dlc),
    .rx_data(rx_data), .tx_done(tx_done), .irq(irq));
  int passed = 0, total = 0;
  typedef struct {logic [10:0] id; logic [3:0] dlc; logic [63:0] data;} frame_t;
  frame_t mq[$];
  bit m_ovf, m_lb, m_irq_en;
  logic [10:0] m_code, m_mask;
  localparam logic [31:0] A_CMD = 32'h00, A_STAT = 32'h04, A_TXID = 32'h08, A_TXDLC = 32'h0C,
    A_TXD0 = 32'h10, A_TXD1 = 32'h14, A_RXID = 32'h18, A_RXDLC = 32'h1C, A_RXD0 = 32'h20,
    A_RXD1 = 32'h24, A_CODE = 32'h28, A_MASK = 32'h2C, A_CTRL = 32'h30;

  function automatic int clamp(logic [3:0] dlc);
    return dlc > 8 ? 8 : int'(dlc);
  endfunction
  function automatic logic [63:0] trim(logic [3:0] dlc, logic [63:0] d);
    int n = clamp(dlc);
    return n == 8 ? d : d & ((64'd1 << (8 * n)) - 64'd1);
  endfunction
  function automatic void model_deliver(logic [10:0] id, logic [3:0] dlc, logic [63:0] d);
    frame_t f;
    if (!m_lb || ((id ^ m_code) & m_mask) != 11'h0) return;
    f.id = id; f.dlc = 4'(clamp(dlc)); f.data = trim(dlc, d);
    if (mq.size() < 4) mq.push_back(f); else m_ovf = 1'b1;
  endfunction
  function automatic logic [31:0] model_status();
    return (32'(mq.size()) << 8) | ((mq.size() == 4) ? 32'h8 : 32'h0) | (m_ovf ? 32'h4 : 32'h0) | (mq.size() > 0 ? 32'h1 : 32'h0);
  endfunction

  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] wdat, output logic [31:0] rdat);
    bit got = 1'b0;
    rdat = 32'h0;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we; bus.wb_adr_i = adr; bus.wb_dat_i = wdat;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus.wb_ack_o) begin got = 1'b1; rdat = bus.wb_dat_o; end
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    if (!got) begin total++; $display("FAIL wb_ack adr=%h got no ack want ack", adr); end
  endtask
  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask
  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, 32'h0, d);
  endtask
  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin @(negedge clk); seen = tx_done; end
    if (!seen) begin total++; $display("FAIL tx_done_wait got no pulse want pulse"); end
  endtask
  task automatic do_reset();
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_lb = 1'b1; m_irq_en = 1'b0; m_code = '0; m_mask = '0;
  endtask
  task automatic send_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [31:0] d0, input logic [31:0] d1);
    wb_wr(A_TXID, 32'(id)); wb_wr(A_TXDLC, 32'(dlc)); wb_wr(A_TXD0, d0); wb_wr(A_TXD1, d1);
    wb_wr(A_CMD, 32'h1);
    wait_done();
    model_deliver(id, dlc, {d1, d0});
  endtask

  task automatic test_reset();
    logic [31:0] r;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_adr_i = '0; bus.wb_dat_i = '0;
    rst = 1'b1; repeat (3) @(negedge clk);
    total++; if ({rx_ready, rx_id, rx_dlc, rx_data, tx_done, irq, bus.wb_ack_o} !== '0) $display("FAIL reset_outputs got nonzero want 0"); else passed++;
    total++; if (bus.wb_dat_o !== 32'h0) $display("FAIL reset_dat_o got %h want 0", bus.wb_dat_o); else passed++;
    rst = 1'b0;
    wb_rd(A_STAT, r);
    total++; if (r !== 32'h0) $display("FAIL reset_status got %h want 0", r); else passed++;
    wb_rd(A_CTRL, r);
    total++; if (r !== 32'h1) $display("FAIL reset_ctrl got %h want 1", r); else passed++;
  endtask

  task automatic test_basic();
    logic [31:0] r;
    do_reset();
    wb_wr(A_TXID, 32'h123); wb_wr(A_TXDLC, 32'h2); wb_wr(A_TXD0, 32'hDDCCBBAA); wb_wr(A_TXD1, 32'h11223344);
    wb_wr(A_CMD, 32'h1);
    wb_rd(A_STAT, r);
    total++; if (r !== 32'h2) $display("FAIL basic_busy got %h want 2", r); else passed++;
    repeat (13) @(negedge clk);
    total++; if (tx_done !== 1'b0) $display("FAIL basic_early_done got %b want 0", tx_done); else passed++;
    @(negedge clk);
    total++; if (tx_done !== 1'b1) $display("FAIL basic_done_at_16 got %b want 1", tx_done); else passed++;
    @(negedge clk);
    total++; if (tx_done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", tx_done); else passed++;
    total++; if ({rx_ready, rx_id, rx_dlc, rx_data} !== {1'b1, 11'h123, 4'h2, 64'h0000BBAA}) $display("FAIL basic_head got %h/%h/%h want 123/2/0000bbaa", rx_id, rx_dlc, rx_data); else passed++;
    wb_rd(A_RXID, r);
    total++; if (r !== 32'h123) $display("FAIL basic_rxid got %h want 123", r); else passed++;
    wb_rd(A_RXD0, r);
    total++; if (r !== 32'h0000BBAA) $display("FAIL basic_rxd0 got %h want 0000bbaa", r); else passed++;
    wb_rd(A_RXD1, r);
    total++; if (r !== 32'h0) $display("FAIL basic_rxd1 got %h want 0", r); else passed++;
    wb_rd(A_STAT, r);
    total++; if (r !== 32'h101) $display("FAIL basic_status got %h want 101", r); else passed++;
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    do_reset();
    wb_wr(A_CTRL, 32'h3);
    for (int i = 0; i < 5; i++) send_frame(11'h10 + 11'(i), 4'h1, 32'(i), 32'h0);
    wb_rd(A_STAT, r);
    total++; if (r !== 32'h40D) $display("FAIL ovf_status got %h want 40d", r); else passed++;
    total++; if ({irq, rx_id} !== {1'b1, 11'h10}) $display("FAIL ovf_irq_head got %b/%h want 1/010", irq, rx_id); else passed++;
    wb_wr(A_CMD, 32'h4);
    wb_rd(A_STAT, r);
    total++; if (r !== 32'h409) $display("FAIL ovf_clear got %h want 409", r); else passed++;
    total++; if (irq !== 1'b1) $display("FAIL ovf_irq_ready got %b want 1", irq); else passed++;
  endtask

  task automatic test_pop_full();
    logic [31:0] r;
    wb_wr(A_TXID, 32'h155); wb_wr(A_TXDLC, 32'hF); wb_wr(A_TXD0, 32'h76543210); wb_wr(A_TXD1, 32'hFEDCBA98);
    wb_wr(A_CMD, 32'h1);
    repeat (15) @(negedge clk);
    wb_wr(A_CMD, 32'h2);
    total++; if (tx_done !== 1'b1) $display("FAIL popfull_align got %b want 1", tx_done); else passed++;
    wb_rd(A_STAT, r);
    total++; if (r !== 32'h409) $display("FAIL popfull_status got %h want 409", r); else passed++;
    total++; if (rx_id !== 11'h11) $display("FAIL popfull_head got %h want 011", rx_id); else passed++;
    repeat (3) wb_wr(A_CMD, 32'h2);
    total++; if ({rx_id, rx_dlc, rx_data} !== {11'h155, 4'h8, 64'hFEDCBA9876543210}) $display("FAIL popfull_tail got %h/%h/%h want 155/8/fedcba9876543210", rx_id, rx_dlc, rx_data); else passed++;
    wb_rd(A_STAT, r);
    total++; if (r !== 32'h101) $display("FAIL popfull_count got %h want 101", r); else passed++;
  endtask

  task automatic test_filter();
    logic [31:0] r;
    do_reset();
    wb_wr(A_MASK, 32'h7FF); wb_wr(A_CODE, 32'h100);
    send_frame(11'h100, 4'h0, 32'h0, 32'h0);
    send_frame(11'h101, 4'h0, 32'h0, 32'h0);
    wb_rd(A_STAT, r);
    total++; if (r !== 32'h101) $display("FAIL filter_count got %h want 101", r); else passed++;
    total++; if (rx_id !== 11'h100) $display("FAIL filter_head got %h want 100", rx_id); else passed++;
    wb_wr(A_CMD, 32'h2);
    total++; if ({rx_ready, rx_id} !== '0) $display("FAIL filter_pop got %b/%h want 0/000", rx_ready, rx_id); else passed++;
    wb_wr(A_CMD, 32'h2);
    wb_rd(A_STAT, r);
    total++; if (r !== 32'h0) $display("FAIL filter_pop_empty got %h want 0", r); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int extra = 0;
    do_reset();
    wb_wr(A_TXID, 32'h2AA); wb_wr(A_TXDLC, 32'h4); wb_wr(A_TXD0, 32'hCAFEF00D);
    wb_wr(A_CMD, 32'h1);
    wb_wr(A_TXID, 32'h0F0);
    wb_wr(A_CMD, 32'h1);
    wait_done();
    for (int k = 0; k < 30; k++) begin @(negedge clk); extra += int'(tx_done); end
    total++; if (extra !== 0) $display("FAIL b2b_extra_done got %0d want 0", extra); else passed++;
    wb_rd(A_STAT, r);
    total++; if (r !== 32'h101) $display("FAIL b2b_status got %h want 101", r); else passed++;
    total++; if ({rx_id, rx_data} !== {11'h2AA, 64'hCAFEF00D}) $display("FAIL b2b_frame got %h/%h want 2aa/cafef00d", rx_id, rx_data); else passed++;
  endtask

  task automatic test_reset_busy();
    logic [31:0] r;
    int seen = 0;
    do_reset();
    send_frame(11'h55, 4'h1, 32'h1, 32'h0);
    wb_wr(A_CMD, 32'h1);
    repeat (5) @(negedge clk);
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 30; k++) begin @(negedge clk); seen += int'(tx_done); end
    total++; if (seen !== 0) $display("FAIL rstbusy_done got %0d want 0", seen); else passed++;
    total++; if ({rx_ready, rx_id, rx_dlc, rx_data, tx_done, irq} !== '0) $display("FAIL rstbusy_outputs got nonzero want 0"); else passed++;
    wb_rd(A_STAT, r);
    total++; if (r !== 32'h0) $display("FAIL rstbusy_status got %h want 0", r); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] r, d0, d1, cmdv;
    logic [10:0] id;
    logic [3:0] dlc;
    frame_t h;
    do_reset();
    for (int it = 0; it < 16; it++) begin
      m_lb = $urandom_range(0, 5) != 0;
      m_irq_en = 1'(($urandom));
      m_mask = $urandom_range(0, 1) ? 11'h0 : 11'($urandom);
      m_code = 11'($urandom);
      wb_wr(A_CTRL, {30'h0, m_irq_en, m_lb}); wb_wr(A_MASK, 32'(m_mask)); wb_wr(A_CODE, 32'(m_code));
      id = $urandom_range(0, 1) ? (m_code ^ (11'($urandom) & ~m_mask)) : 11'($urandom);
      dlc = 4'($urandom_range(0, 15)); d0 = $urandom; d1 = $urandom;
      send_frame(id, dlc, d0, d1);
      cmdv = {29'h0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1'b0};
      if (cmdv != 0) begin
        wb_wr(A_CMD, cmdv);
        if (cmdv[2]) m_ovf = 1'b0;
        if (cmdv[1] && mq.size() > 0) void'(mq.pop_front());
      end
      wb_rd(A_STAT, r);
      total++; if (r !== model_status()) $display("FAIL rand_status it=%0d got %h want %h", it, r, model_status()); else passed++;
      total++; if (irq !== (m_irq_en && (mq.size() > 0 || m_ovf))) $display("FAIL rand_irq it=%0d got %b", it, irq); else passed++;
      h.id = '0; h.dlc = '0; h.data = '0;
      if (mq.size() > 0) h = mq[0];
      total++; if ({rx_ready, rx_id, rx_dlc, rx_data} !== {mq.size() > 0, h.id, h.dlc, h.data}) $display("FAIL rand_head it=%0d got %h/%h/%h want %h/%h/%h", it, rx_id, rx_dlc, rx_data, h.id, h.dlc, h.data); else passed++;
      wb_rd(A_RXD1, r);
      total++; if (r !== h.data[63:32]) $display("FAIL rand_rxd1 it=%0d got %h want %h", it, r, h.data[63:32]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_pop_full();
    test_filter();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
